// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the APB master arbiter.
//   ADDR_W/DATA_W/DEV_W : register address, data and device-id widths
//   state_t             : transfer sequencer states
//   apb_req_t           : latched request payload of the current winner
package apb_arb_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEV_W  = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DEV_W-1:0]  device;
  } apb_req_t;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signal bundle of the arbiter.
//   master modport : the arbiter (drives req_ready, rsp_*, paddr/pwdata/pwrite/psel/penable)
//   slave modport  : requesters plus APB slaves (drive req_*, prdata/pready/pslverr)
// Request fields are packed per requester i at [W*i +: W].
interface apb_master_arbiter_if #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned NUM_DEVICES = 4
);
  import apb_arb_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_W-1:0]     req_addr;
  logic [NUM_REQ*DATA_W-1:0]     req_wdata;
  logic [NUM_REQ*DEV_W-1:0]      req_device;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_W-1:0]             rsp_rdata;
  logic                          rsp_err;
  logic [ADDR_W-1:0]             paddr;
  logic [DATA_W-1:0]             pwdata;
  logic                          pwrite;
  logic [NUM_DEVICES-1:0]        psel;
  logic                          penable;
  logic [NUM_DEVICES*DATA_W-1:0] prdata;
  logic [NUM_DEVICES-1:0]        pready;
  logic [NUM_DEVICES-1:0]        pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_device, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwdata, pwrite, psel, penable
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_device, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwdata, pwrite, psel, penable
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request bit at/after (last_grant_i + 1) mod NUM_REQ.
//   req_i        : request vector
//   last_grant_i : index of the previous winner
//   grant_o      : one-hot grant (all zero when no request)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic            found;
  logic [IdxW-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = IdxW'((32'(last_grant_i) + off) % NUM_REQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters: round-robin arbitration, then
// IDLE->SETUP->ACCESS sequencing, one-hot psel decode, slave response mux and a one-cycle
// response pulse to the winner.
//   clk, rst : clock, synchronous active-high reset
//   bus_io   : requester handshake and APB bus (apb_master_arbiter_if.master)
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles
// without pready (response carries rsp_err=1, rsp_rdata=0).
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned NUM_DEVICES    = 4
`ifdef APB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input logic                  clk,
  input logic                  rst,
  apb_master_arbiter_if.master bus_io
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                 state_q, state_d;
  apb_req_t               req_q, req_d, win_req;
  logic [NUM_REQ-1:0]     grant_oh, grant_q, grant_d, accept;
  logic [IdxW-1:0]        last_q, last_d, win_idx;
  logic [DATA_W-1:0]      rdata_q, rdata_d, sel_rdata;
  logic                   err_q, err_d, sel_ready, sel_err;
  logic [ADDR_W-1:0]      paddr_q, paddr_d;
  logic [DATA_W-1:0]      pwdata_q, pwdata_d;
  logic                   pwrite_q, pwrite_d;
  logic [NUM_DEVICES-1:0] dev_oh;
`ifdef APB_TIMEOUT_EN
  logic [7:0]             tmo_q, tmo_d;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr_arbiter (
    .req_i        (bus_io.req_valid),
    .last_grant_i (last_q),
    .grant_o      (grant_oh)
  );

  // Payload of the requester picked by the arbiter this cycle.
  always_comb begin
    win_req = '0;
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        win_idx        = IdxW'(i);
        win_req.write  = bus_io.req_write[i];
        win_req.addr   = bus_io.req_addr[i*ADDR_W +: ADDR_W];
        win_req.wdata  = bus_io.req_wdata[i*DATA_W +: DATA_W];
        win_req.device = bus_io.req_device[i*DEV_W +: DEV_W];
      end
    end
  end

  // Only the addressed slave is observed; the others are ignored.
  always_comb begin
    dev_oh    = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
      if (32'(req_q.device) == d) begin
        dev_oh[d] = 1'b1;
        sel_ready = bus_io.pready[d];
        sel_err   = bus_io.pslverr[d];
        sel_rdata = bus_io.prdata[d*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    grant_d  = grant_q;
    last_d   = last_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    accept   = '0;
`ifdef APB_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Gated by rst so no accept pulse escapes while reset is held.
        if (!rst && (|bus_io.req_valid)) begin
          accept  = grant_oh;
          req_d   = win_req;
          grant_d = grant_oh;
          last_d  = win_idx;
          if (32'(win_req.device) < NUM_DEVICES) begin
            state_d  = SETUP;
            paddr_d  = win_req.addr;
            pwdata_d = win_req.wdata;
            pwrite_d = win_req.write;
`ifdef APB_TIMEOUT_EN
            tmo_d    = '0;
`endif
          end else begin
            // Unknown device: answer with an error without touching the bus.
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          state_d = RESP;
          err_d   = sel_err;
          rdata_d = (!req_q.write && !sel_err) ? sel_rdata : '0;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      grant_q  <= '0;
      last_q   <= IdxW'(NUM_REQ - 1);
      rdata_q  <= '0;
      err_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
`ifdef APB_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign bus_io.req_ready = accept;
  assign bus_io.psel      = (state_q == SETUP || state_q == ACCESS) ? dev_oh : '0;
  assign bus_io.penable   = (state_q == ACCESS);
  assign bus_io.rsp_valid = (state_q == RESP) ? grant_q : '0;
  assign bus_io.rsp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign bus_io.rsp_err   = (state_q == RESP) && err_q;
  assign bus_io.paddr     = paddr_q;
  assign bus_io.pwdata    = pwdata_q;
  assign bus_io.pwrite    = pwrite_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned ND = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_master_arbiter_if #(.NUM_REQ(NR), .NUM_DEVICES(ND)) bus ();

  apb_master_arbiter #(
    .NUM_REQ     (NR),
    .NUM_DEVICES (ND)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         g;
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    logic [3:0] dev;
    int         wt;
    logic [7:0] rd;
    bit         se;
    logic [3:0] exp_psel;
    bit         exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Target slave answers as given; all other slaves look ready with an error and junk data.
  task automatic set_slaves(input int tgt, input bit rdy, input logic [7:0] rd, input bit se);
    for (int d = 0; d < int'(ND); d++) begin
      if (d == tgt) begin
        bus.pready[d] = rdy;
        bus.pslverr[d] = se;
        bus.prdata[d*8 +: 8] = rd;
      end else begin
        bus.pready[d] = 1'b1;
        bus.pslverr[d] = 1'b1;
        bus.prdata[d*8 +: 8] = 8'hEE;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    next();
    next();
    rst = 1'b0;
  endtask

  // Starts at the beginning of an IDLE cycle, ends at the beginning of the next IDLE cycle.
  task automatic xfer(input int g, input bit w, input logic [7:0] a, input logic [7:0] d,
                      input logic [3:0] dev, input int wt, input logic [7:0] rd, input bit se,
                      input logic [3:0] exp_psel, input bit exp_err, input logic [7:0] exp_rdata,
                      input string tag);
    logic [7:0] prev_addr;
    prev_addr = bus.paddr;
    bus.req_valid[g] = 1'b1;
    bus.req_write[g] = w;
    bus.req_addr[g*8 +: 8] = a;
    bus.req_wdata[g*8 +: 8] = d;
    bus.req_device[g*4 +: 4] = dev;
    set_slaves(int'(dev), 1'b0, rd, se);
    #1;
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(1) << g);
    next();
    bus.req_valid[g] = 1'b0;
    #1;
    if (exp_psel == 4'd0) begin
      chk({tag, " bad-dev rsp_valid"}, 32'(bus.rsp_valid), 32'(1) << g);
      chk({tag, " bad-dev rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
      chk({tag, " bad-dev rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
      chk({tag, " bad-dev psel"}, 32'(bus.psel), 32'd0);
      chk({tag, " bad-dev paddr held"}, 32'(bus.paddr), 32'(prev_addr));
    end else begin
      chk({tag, " setup psel"}, 32'(bus.psel), 32'(exp_psel));
      chk({tag, " setup penable"}, 32'(bus.penable), 32'd0);
      chk({tag, " setup paddr"}, 32'(bus.paddr), 32'(a));
      chk({tag, " setup pwdata"}, 32'(bus.pwdata), 32'(d));
      chk({tag, " setup pwrite"}, 32'(bus.pwrite), 32'(w));
      chk({tag, " setup req_ready"}, 32'(bus.req_ready), 32'd0);
      for (int k = 0; k <= wt; k++) begin
        next();
        set_slaves(int'(dev), k == wt, rd, se);
        #1;
        chk({tag, " access psel"}, 32'(bus.psel), 32'(exp_psel));
        chk({tag, " access penable"}, 32'(bus.penable), 32'd1);
        chk({tag, " access rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      end
      next();
      set_slaves(int'(dev), 1'b0, rd, se);
      #1;
      chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(1) << g);
      chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
      chk({tag, " rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
      chk({tag, " rsp psel"}, 32'(bus.psel), 32'd0);
      chk({tag, " rsp penable"}, 32'(bus.penable), 32'd0);
    end
    next();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int         gseq[$];
    int         gcyc[$];
    bit         pend[NR];
    logic       pw[NR];
    logic [7:0] pa[NR];
    logic [7:0] pd[NR];
    logic [3:0] pdev[NR];
    int         last;
    int         bad;
    int         n;
    bit         seen;
    logic       s_err;
    logic [7:0] s_rd;
    logic [3:0] s_psel;

    vt[0] = '{0, 1'b1, 8'h1E, 8'h01, 4'd1, 0, 8'h00, 1'b0, 4'b0010, 1'b0, 8'h00};
    vt[1] = '{1, 1'b0, 8'h05, 8'h00, 4'd2, 3, 8'hA5, 1'b0, 4'b0100, 1'b0, 8'hA5};
    vt[2] = '{0, 1'b1, 8'h33, 8'h77, 4'd9, 0, 8'h00, 1'b0, 4'b0000, 1'b1, 8'h00};
    vt[3] = '{1, 1'b0, 8'h10, 8'h00, 4'd3, 0, 8'h5C, 1'b1, 4'b1000, 1'b1, 8'h00};
    vt[4] = '{0, 1'b0, 8'h7F, 8'h00, 4'd0, 1, 8'h3C, 1'b0, 4'b0001, 1'b0, 8'h3C};
    vt[5] = '{1, 1'b1, 8'hC0, 8'hFF, 4'd3, 2, 8'h99, 1'b0, 4'b1000, 1'b0, 8'h00};
    vt[6] = '{0, 1'b0, 8'h44, 8'h00, 4'd4, 0, 8'h12, 1'b0, 4'b0000, 1'b1, 8'h00};

    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_write = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_device = '0;
    bus.prdata = '0;
    bus.pready = '0;
    bus.pslverr = '0;

    // Reset state, with requests pending while reset is held.
    next();
    next();
    #1;
    chk("reset req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset psel", 32'(bus.psel), 32'd0);
    chk("reset penable", 32'(bus.penable), 32'd0);
    chk("reset paddr", 32'(bus.paddr), 32'd0);
    chk("reset pwdata", 32'(bus.pwdata), 32'd0);
    chk("reset pwrite", 32'(bus.pwrite), 32'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    next();

    // Directed single-requester vectors.
    for (int i = 0; i < 7; i++) begin
      xfer(vt[i].g, vt[i].w, vt[i].a, vt[i].d, vt[i].dev, vt[i].wt, vt[i].rd, vt[i].se,
           vt[i].exp_psel, vt[i].exp_err, vt[i].exp_rdata, $sformatf("vec%0d", i));
    end

    // Both requesters held high: grants alternate 0,1,0,1, one accept every 4 cycles.
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    bus.req_device = '0;
    set_slaves(0, 1'b1, 8'h00, 1'b0);
    for (int c = 0; c < 40 && gseq.size() < 4; c++) begin
      #1;
      if (bus.req_ready != '0) begin
        gseq.push_back(bus.req_ready == 2'b01 ? 0 : (bus.req_ready == 2'b10 ? 1 : 9));
        gcyc.push_back(c);
      end
      next();
    end
    bus.req_valid = '0;
    chk("rr grant count", 32'(gseq.size()), 32'd4);
    for (int i = 0; i < gseq.size(); i++) begin
      chk($sformatf("rr grant %0d", i), 32'(gseq[i]), 32'(i % 2));
      if (i > 0) chk($sformatf("rr spacing %0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd4);
    end

    // Reset in the middle of ACCESS drops the transfer.
    do_reset();
    next();
    bus.req_valid[0] = 1'b1;
    bus.req_write[0] = 1'b0;
    bus.req_addr[7:0] = 8'h44;
    bus.req_device[3:0] = 4'd3;
    set_slaves(3, 1'b0, 8'h11, 1'b0);
    next();
    bus.req_valid[0] = 1'b0;
    next();
    #1;
    chk("mid-rst penable before", 32'(bus.penable), 32'd1);
    rst = 1'b1;
    next();
    #1;
    chk("mid-rst psel", 32'(bus.psel), 32'd0);
    chk("mid-rst penable", 32'(bus.penable), 32'd0);
    chk("mid-rst paddr", 32'(bus.paddr), 32'd0);
    chk("mid-rst pwrite", 32'(bus.pwrite), 32'd0);
    chk("mid-rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    set_slaves(3, 1'b1, 8'h11, 1'b0);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      next();
      #1;
      if (bus.rsp_valid != '0 || bus.psel != '0) bad++;
    end
    chk("mid-rst no response", 32'(bad), 32'd0);

    // Slave that never answers.
    bus.req_valid[0] = 1'b1;
    bus.req_write[0] = 1'b0;
    bus.req_addr[7:0] = 8'h22;
    bus.req_device[3:0] = 4'd2;
    set_slaves(2, 1'b0, 8'h5A, 1'b0);
    next();
    bus.req_valid[0] = 1'b0;
    next();
`ifdef APB_TIMEOUT_EN
    n = 0;
    seen = 1'b0;
    s_err = 1'b0;
    s_rd = 8'h00;
    s_psel = 4'h0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.rsp_valid != '0) begin
        seen = 1'b1;
        s_err = bus.rsp_err;
        s_rd = bus.rsp_rdata;
        s_psel = bus.psel;
        break;
      end
      if (bus.penable) n++;
      next();
    end
    chk("timeout response seen", 32'(seen), 32'd1);
    chk("timeout access cycles", 32'(n), 32'd16);
    chk("timeout rsp_err", 32'(s_err), 32'd1);
    chk("timeout rsp_rdata", 32'(s_rd), 32'd0);
    chk("timeout psel", 32'(s_psel), 32'd0);
`else
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (bus.penable !== 1'b1 || bus.psel !== 4'b0100 || bus.rsp_valid !== 2'b00) bad++;
      next();
    end
    chk("stall still in access", 32'(bad), 32'd0);
    set_slaves(2, 1'b1, 8'h5A, 1'b0);
    next();
    #1;
    chk("stall rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("stall rsp_rdata", 32'(bus.rsp_rdata), 32'h5A);
    chk("stall rsp_err", 32'(bus.rsp_err), 32'd0);
`endif
    next();

    // Random traffic against a queue-free behavioural model: pending requests stay stable
    // until granted; the winner is the first pending index after the previous winner.
    do_reset();
    next();
    last = int'(NR) - 1;
    for (int i = 0; i < int'(NR); i++) pend[i] = 1'b0;
    for (int t = 0; t < 60; t++) begin
      int         g;
      int         wt;
      logic [7:0] rd;
      bit         se;
      bit         dvalid;
      for (int i = 0; i < int'(NR); i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pw[i] = 1'($urandom_range(0, 1));
          pa[i] = 8'($urandom);
          pd[i] = 8'($urandom);
          pdev[i] = 4'($urandom_range(0, 5));
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[1] = 1'b1;
        pw[1] = 1'b0;
        pa[1] = 8'($urandom);
        pd[1] = 8'($urandom);
        pdev[1] = 4'($urandom_range(0, 3));
      end
      for (int i = 0; i < int'(NR); i++) begin
        bus.req_valid[i] = pend[i];
        bus.req_write[i] = pw[i];
        bus.req_addr[i*8 +: 8] = pa[i];
        bus.req_wdata[i*8 +: 8] = pd[i];
        bus.req_device[i*4 +: 4] = pdev[i];
      end
      g = -1;
      for (int off = 1; off <= int'(NR); off++) begin
        int c;
        c = (last + off) % int'(NR);
        if (g < 0 && pend[c]) g = c;
      end
      last = g;
      wt = $urandom_range(0, 3);
      rd = 8'($urandom);
      se = ($urandom_range(0, 3) == 0);
      dvalid = (int'(pdev[g]) < int'(ND));
      xfer(g, pw[g], pa[g], pd[g], pdev[g], wt, rd, se,
           dvalid ? 4'(1 << pdev[g]) : 4'd0,
           !dvalid || se,
           (dvalid && !pw[g] && !se) ? rd : 8'h00,
           $sformatf("rand%0d", t));
      pend[g] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
